// File: rtl/mic_array_detector.sv
// Multi-channel sound detector: debounces CHANNELS mic inputs, classifies short/long sounds, arbitrates events, drives wake and buzzer.
// Optional MIC_DOUBLE_CLAP_EN: signal_awake fires only on the second event within CLAP_WINDOW cycles.
module mic_array_detector #(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DEBOUNCE    = 50,
  parameter int unsigned LONG_PULSE  = 1000,
  parameter int unsigned BUZZ_LEN    = 5000,
  parameter int unsigned BUZZ_HALF   = 25,
  parameter int unsigned CLAP_WINDOW = 2000
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [CHANNELS-1:0]                               mic,
  input  logic                                              enable,
  output logic                                              signal_awake,
  output logic                                              event_valid,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] event_ch,
  output logic                                              event_long,
  output logic                                              buzzer,
  output logic                                              busy
);

  localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned CNT_W  = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam int unsigned WID_W  = $clog2(LONG_PULSE + 1);
  localparam int unsigned LEN_W  = $clog2(BUZZ_LEN + 1);
  localparam int unsigned HALF_W = $clog2(2 * BUZZ_HALF + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BEEP = 1'b1;

  if (CHANNELS == 0 || CHANNELS > 8 || DEBOUNCE == 0 || BUZZ_LEN == 0 ||
      BUZZ_HALF == 0 || CLAP_WINDOW == 0) begin : g_param_check
    $error("mic_array_detector: parameter out of range");
  end

  logic [CHANNELS-1:0] sync1, sync2, deb, pending, long_q;
  logic [CNT_W-1:0]    deb_cnt [CHANNELS];
  logic [WID_W-1:0]    width   [CHANNELS];
  logic [CHANNELS-1:0] settle_c, rise_c, capture_c, gmask_c;
  logic [CH_W-1:0]     gidx_c;
  logic                any_c, found_c;

  // Debounce transitions and lowest-index grant
  always_comb begin
    settle_c = '0;
    gidx_c   = '0;
    found_c  = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      settle_c[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == CNT_W'(DEBOUNCE - 1));
      if (pending[i] && !found_c) begin
        found_c = 1'b1;
        gidx_c  = CH_W'(i);
      end
    end
    rise_c    = settle_c & sync2;
    capture_c = settle_c & ~sync2 & {CHANNELS{enable}};
    any_c     = |pending;
    gmask_c   = pending & (~pending + CHANNELS'(1));
  end

  // Per-channel sync, debounce, width measurement and capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1   <= '0;
      sync2   <= '0;
      deb     <= '0;
      pending <= '0;
      long_q  <= '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        deb_cnt[i] <= '0;
        width[i]   <= '0;
      end
    end else begin
      sync1 <= mic;
      sync2 <= sync1;
      for (int i = 0; i < int'(CHANNELS); i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (settle_c[i]) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
        if (rise_c[i]) begin
          width[i] <= '0;
        end else if (deb[i] && width[i] != WID_W'(LONG_PULSE)) begin
          width[i] <= width[i] + 1'b1;
        end
        if (capture_c[i]) begin
          long_q[i] <= (width[i] >= WID_W'(LONG_PULSE));
        end
      end
      // A capture landing on the channel being granted re-arms it as a new event
      pending <= (pending & ~gmask_c) | capture_c;
    end
  end

  // Event port
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      event_valid <= 1'b0;
      event_ch    <= '0;
      event_long  <= 1'b0;
    end else begin
      event_valid <= any_c;
      event_ch    <= any_c ? gidx_c : '0;
      event_long  <= |(long_q & gmask_c);
    end
  end

`ifdef MIC_DOUBLE_CLAP_EN
  localparam int unsigned WIN_W = $clog2(CLAP_WINDOW + 1);

  logic [WIN_W-1:0] win_cnt;
  logic             awake_q;

  // Window opens on an event; a second event inside it wakes and closes it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_cnt <= '0;
      awake_q <= 1'b0;
    end else if (any_c) begin
      if (win_cnt != '0) begin
        awake_q <= 1'b1;
        win_cnt <= '0;
      end else begin
        awake_q <= 1'b0;
        win_cnt <= WIN_W'(CLAP_WINDOW);
      end
    end else begin
      awake_q <= 1'b0;
      if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
    end
  end

  assign signal_awake = awake_q;
`else
  assign signal_awake = event_valid;
`endif

  logic [0:0]        state, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [HALF_W-1:0] half_q, half_d, ph_q, ph_d;
  logic              buzz_d;

  // Buzzer FSM next state
  always_comb begin
    state_d = state;
    len_d   = len_q;
    half_d  = half_q;
    ph_d    = ph_q;
    buzz_d  = buzzer;
    case (state)
      S_IDLE: begin
        if (event_valid) begin
          state_d = S_BEEP;
          len_d   = LEN_W'(BUZZ_LEN);
          half_d  = event_long ? HALF_W'(2 * BUZZ_HALF) : HALF_W'(BUZZ_HALF);
          ph_d    = '0;
          buzz_d  = 1'b1;
        end
      end
      S_BEEP: begin
        if (ph_q >= half_q - 1'b1) begin
          ph_d   = '0;
          buzz_d = ~buzzer;
        end else begin
          ph_d = ph_q + 1'b1;
        end
        if (event_valid) begin
          len_d  = LEN_W'(BUZZ_LEN);
          half_d = event_long ? HALF_W'(2 * BUZZ_HALF) : HALF_W'(BUZZ_HALF);
        end else if (len_q == LEN_W'(1)) begin
          state_d = S_IDLE;
          len_d   = '0;
          ph_d    = '0;
          buzz_d  = 1'b0;
        end else begin
          len_d = len_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        buzz_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      len_q  <= '0;
      half_q <= '0;
      ph_q   <= '0;
      buzzer <= 1'b0;
    end else begin
      state  <= state_d;
      len_q  <= len_d;
      half_q <= half_d;
      ph_q   <= ph_d;
      buzzer <= buzz_d;
    end
  end

  assign busy = (state == S_BEEP);

endmodule

// File: tb/tb_mic_array_detector.sv
// Directed self-checking bench for mic_array_detector (CHANNELS=2, DEBOUNCE=4, LONG_PULSE=20, BUZZ_LEN=40, BUZZ_HALF=2).
module tb_mic_array_detector;

  localparam int LOGN = 4096;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mic = 2'b00;
  logic       enable = 1'b1;
  logic       signal_awake, event_valid, event_long, buzzer, busy;
  logic [0:0] event_ch;

  mic_array_detector #(
    .CHANNELS(2), .DEBOUNCE(4), .LONG_PULSE(20),
    .BUZZ_LEN(40), .BUZZ_HALF(2), .CLAP_WINDOW(100)
  ) dut (
    .clk(clk), .rst(rst), .mic(mic), .enable(enable),
    .signal_awake(signal_awake), .event_valid(event_valid),
    .event_ch(event_ch), .event_long(event_long),
    .buzzer(buzzer), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   ev_cyc[$];
  int   ev_ch[$];
  int   ev_long[$];
  int   awake_cnt = 0;
  logic buz_log   [LOGN];
  logic busy_log  [LOGN];
  logic awake_log [LOGN];

  // Record outputs mid-cycle
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      buz_log[cyc]   <= buzzer;
      busy_log[cyc]  <= busy;
      awake_log[cyc] <= signal_awake;
    end
    if (event_valid) begin
      ev_cyc.push_back(cyc);
      ev_ch.push_back(int'(event_ch));
      ev_long.push_back(int'(event_long));
    end
    if (signal_awake) awake_cnt <= awake_cnt + 1;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int ch, input int hi);
    mic[ch] = 1'b1;
    tick(hi);
    mic[ch] = 1'b0;
  endtask

  task automatic check_one_event(input string tag, input int n0, input int exp_cyc,
                                 input int exp_ch, input int exp_long);
    check({tag, "_count"}, ev_cyc.size() - n0, 1);
    if (ev_cyc.size() > n0) begin
      check({tag, "_cyc"},  ev_cyc[n0],  exp_cyc);
      check({tag, "_ch"},   ev_ch[n0],   exp_ch);
      check({tag, "_long"}, ev_long[n0], exp_long);
    end
  endtask

  // Buzzer square wave and busy window following an event at cycle e
  task automatic check_beep(input string tag, input int e, input int half);
    for (int k = 1; k <= 40; k++) begin
      check({tag, "_buz"},  buz_log[e + k],  (((k - 1) / half) % 2) == 0);
      check({tag, "_busy"}, busy_log[e + k], 1);
    end
    check({tag, "_busy_end"}, busy_log[e + 41], 0);
    check({tag, "_buz_end"},  buz_log[e + 41],  0);
  endtask

  initial begin
    int n0, f, f1, f2, f3, f4;

    // Reset held with mic toggling
    for (int i = 0; i < 10; i++) begin
      mic = ~mic;
      tick(1);
      check("rst_valid", event_valid, 0);
      check("rst_buzzer", buzzer, 0);
    end
    check("rst_awake", signal_awake, 0);
    check("rst_ch", event_ch, 0);
    check("rst_long", event_long, 0);
    check("rst_busy", busy, 0);
    mic = 2'b00;
    rst = 1'b1;
    tick(50);
    check("idle_no_event", ev_cyc.size(), 0);

    // Three-cycle glitch is rejected
    n0 = ev_cyc.size();
    pulse(0, 3);
    tick(20);
    check("glitch3", ev_cyc.size() - n0, 0);

    // Four-cycle pulse is just enough to pass the debouncer
    n0 = ev_cyc.size();
    pulse(0, 4);
    f = cyc;
    tick(60);
    check_one_event("pulse4", n0, f + 7, 0, 0);

    // Short sound: latency, buzzer period 4
    n0 = ev_cyc.size();
    pulse(0, 10);
    f = cyc;
    tick(60);
    check_one_event("short", n0, f + 7, 0, 0);
`ifndef MIC_DOUBLE_CLAP_EN
    check("short_awake", awake_log[f + 7], 1);
    check("short_awake_after", awake_log[f + 8], 0);
`endif
    check_beep("short", f + 7, 2);

    // Long sound on channel 1: buzzer period 8
    n0 = ev_cyc.size();
    pulse(1, 30);
    f = cyc;
    tick(60);
    check_one_event("long", n0, f + 7, 1, 1);
    check_beep("long", f + 7, 4);

    // Long threshold: 20 high cycles short, 21 long
    n0 = ev_cyc.size();
    pulse(1, 20);
    f = cyc;
    tick(60);
    check_one_event("thr20", n0, f + 7, 1, 0);
    n0 = ev_cyc.size();
    pulse(1, 21);
    f = cyc;
    tick(60);
    check_one_event("thr21", n0, f + 7, 1, 1);

    // Simultaneous release: reported in index order, buzzer retriggered
    n0 = ev_cyc.size();
    mic = 2'b11;
    tick(10);
    mic = 2'b00;
    f = cyc;
    tick(60);
    check("simul_count", ev_cyc.size() - n0, 2);
    if (ev_cyc.size() >= n0 + 2) begin
      check("simul_cyc0", ev_cyc[n0], f + 7);
      check("simul_ch0", ev_ch[n0], 0);
      check("simul_cyc1", ev_cyc[n0 + 1], f + 8);
      check("simul_ch1", ev_ch[n0 + 1], 1);
    end
    check("simul_busy_last", busy_log[f + 48], 1);
    check("simul_busy_end", busy_log[f + 49], 0);

    // Enable gating
    n0 = ev_cyc.size();
    enable = 1'b0;
    pulse(0, 10);
    tick(30);
    check("gated", ev_cyc.size() - n0, 0);
    mic[0] = 1'b1;
    tick(10);
    enable = 1'b1;
    tick(5);
    mic[0] = 1'b0;
    f = cyc;
    tick(60);
    check_one_event("reenable", n0, f + 7, 0, 0);

    // Reset mid-beep clears buzzer asynchronously
    n0 = ev_cyc.size();
    pulse(0, 10);
    f = cyc;
    tick(17);
    check("midbeep_buz", buzzer, 1);
    check("midbeep_busy", busy, 1);
    rst = 1'b0;
    #1;
    check("arst_buz", buzzer, 0);
    check("arst_busy", busy, 0);
    tick(3);
    rst = 1'b1;
    tick(30);
    check("arst_events", ev_cyc.size() - n0, 1);

`ifdef MIC_DOUBLE_CLAP_EN
    // Double clap within the window wakes on the second event only
    tick(150);
    n0 = ev_cyc.size();
    pulse(0, 10);
    f1 = cyc;
    tick(50);
    pulse(0, 10);
    f2 = cyc;
    tick(20);
    check("clap60_events", ev_cyc.size() - n0, 2);
    check("clap60_first", awake_log[f1 + 7], 0);
    check("clap60_second", awake_log[f2 + 7], 1);
    tick(130);
    n0 = ev_cyc.size();
    pulse(0, 10);
    f3 = cyc;
    tick(140);
    pulse(0, 10);
    f4 = cyc;
    tick(20);
    check("clap150_events", ev_cyc.size() - n0, 2);
    check("clap150_first", awake_log[f3 + 7], 0);
    check("clap150_second", awake_log[f4 + 7], 0);
    check("clap_awake_total", awake_cnt, 1);
`else
    f1 = 0; f2 = 0; f3 = 0; f4 = 0;
    check("awake_total", awake_cnt, ev_cyc.size());
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
